// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that streams operands through a single 4-bit
// Kogge-Stone slice, least-significant nibble first, with a registered ripple carry.

module ksa (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g, p, g1, p1, g2, p2;
    logic [4:0] c;

    always_comb begin
        g = A & B;
        p = A ^ B;

        // Distance-1 prefix level
        g1[0] = g[0];
        p1[0] = p[0];
        g1[1] = g[1] | (p[1] & g[0]);
        p1[1] = p[1] & p[0];
        g1[2] = g[2] | (p[2] & g[1]);
        p1[2] = p[2] & p[1];
        g1[3] = g[3] | (p[3] & g[2]);
        p1[3] = p[3] & p[2];

        // Distance-2 prefix level; each bit now spans down to bit 0
        g2[1:0] = g1[1:0];
        p2[1:0] = p1[1:0];
        g2[2] = g1[2] | (p1[2] & g1[0]);
        p2[2] = p1[2] & p1[0];
        g2[3] = g1[3] | (p1[3] & g1[1]);
        p2[3] = p1[3] & p1[1];

        c[0] = Cin;
        c[1] = g2[0] | (p2[0] & Cin);
        c[2] = g2[1] | (p2[1] & Cin);
        c[3] = g2[2] | (p2[2] & Cin);
        c[4] = g2[3] | (p2[3] & Cin);

        S    = p ^ c[3:0];
        Cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             c_q;
    logic [IW-1:0]    idx_q;

    logic [3:0] sl_a_d, sl_b_d, sl_s_d;
    logic       sl_c_d;
    logic       last_d;

    assign sl_a_d = a_q[4*idx_q +: 4];
    assign sl_b_d = b_q[4*idx_q +: 4];
    assign last_d = (idx_q == IW'(NIB - 1));

    ksa u_ksa (
        .A    (sl_a_d),
        .B    (sl_b_d),
        .Cin  (c_q),
        .S    (sl_s_d),
        .Cout (sl_c_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        c_q     <= Cin;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    S[4*idx_q +: 4] <= sl_s_d;
                    c_q             <= sl_c_d;
                    idx_q           <= idx_q + IW'(1);
                    if (last_d) begin
                        Cout    <= sl_c_d;
                        V       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (sl_s_d[3] != a_q[WIDTH-1]);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
